// File: rtl/mini_src_pkg.sv
// Shared widths and strobe orderings for the Mini SRC phase-1 datapath.
// Strobe vectors are indexed so that a lower index means higher priority.
package mini_src_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  // ALU operation strobes, highest priority first
  localparam int NUM_OPS  = 14;
  localparam int OP_INCPC = 0;
  localparam int OP_ADD   = 1;
  localparam int OP_SUB   = 2;
  localparam int OP_AND   = 3;
  localparam int OP_OR    = 4;
  localparam int OP_SHR   = 5;
  localparam int OP_SHRA  = 6;
  localparam int OP_SHL   = 7;
  localparam int OP_ROR   = 8;
  localparam int OP_ROL   = 9;
  localparam int OP_NEG   = 10;
  localparam int OP_NOT   = 11;
  localparam int OP_MUL   = 12;
  localparam int OP_DIV   = 13;

  // Bus sources: indices 0..15 are R0..R15, the rest follow in priority order
  localparam int NUM_SRCS   = 24;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHIGH  = 18;
  localparam int SRC_ZLOW   = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  typedef logic [DATA_W-1:0]   word_t;
  typedef logic [2*DATA_W-1:0] dword_t;

  // Immediate constant field of IR, sign-extended onto the bus
  function automatic word_t sext_c(input logic [18:0] c_field);
    return {{13{c_field[18]}}, c_field};
  endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: A comes from Y, B from the bus, 64-bit result feeds Z.
// The first asserted operation strobe (in package order) selects the result.
module dp_alu
  import mini_src_pkg::*;
(
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [NUM_OPS-1:0]  op,
  output logic [2*DATA_W-1:0] result
);

  logic [4:0] sh;
  dword_t     a_ext, b_ext, rot_r, rot_l;
  logic       a_neg, b_neg;
  word_t      a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;

  assign sh    = b[4:0];
  assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_ext = {{DATA_W{b[DATA_W-1]}}, b};
  assign rot_r = {a, a} >> sh;
  assign rot_l = {a, a} << sh;

  // Signed division on magnitudes keeps the overflow case (-2^31 / -1) well defined
  assign a_neg = a[DATA_W-1];
  assign b_neg = b[DATA_W-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign b_div = (b == '0) ? word_t'(1) : b_mag;
  assign q_mag = a_mag / b_div;
  assign r_mag = a_mag % b_div;
  assign quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

  always_comb begin
    // NOTE: a default assignment on entry to every always_comb path prevents latch inference.
    result = '0;
    if      (op[OP_INCPC]) result[DATA_W-1:0] = b + 32'd1;
    else if (op[OP_ADD])   result[DATA_W-1:0] = a + b;
    else if (op[OP_SUB])   result[DATA_W-1:0] = a - b;
    else if (op[OP_AND])   result[DATA_W-1:0] = a & b;
    else if (op[OP_OR])    result[DATA_W-1:0] = a | b;
    else if (op[OP_SHR])   result[DATA_W-1:0] = a >> sh;
    else if (op[OP_SHRA])  result[DATA_W-1:0] = $signed(a) >>> sh;
    else if (op[OP_SHL])   result[DATA_W-1:0] = a << sh;
    else if (op[OP_ROR])   result[DATA_W-1:0] = rot_r[DATA_W-1:0];
    else if (op[OP_ROL])   result[DATA_W-1:0] = rot_l[2*DATA_W-1:DATA_W];
    else if (op[OP_NEG])   result[DATA_W-1:0] = -a;
    else if (op[OP_NOT])   result[DATA_W-1:0] = ~a;
    else if (op[OP_MUL])   result = a_ext * b_ext;
    else if (op[OP_DIV] && b != '0) result = {rem, quo};
  end

endmodule

// File: rtl/data_path.sv
// Mini SRC phase-1 single-bus datapath: register file, special registers,
// one-hot bus source select and the ALU path from Y and the bus into Z.
module data_path
  import mini_src_pkg::*;
(
  input  logic clock,
  input  logic clear,
  input  logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin,
  input  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
  input  logic IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV,
  input  logic Read,
  input  logic [31:0] Mdatain,
  output logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7,
  output logic [31:0] R8, R9, R10, R11, R12, R13, R14, R15,
  output logic [31:0] HI, LO, PC_out, IR, MAR, Y,
  output logic [63:0] Z,
  output logic [31:0] BusMuxOut_signal
);

  word_t  gpr [NUM_REGS];
  word_t  hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, y_q;
  dword_t z_q, alu_result;
  word_t  bus;
  word_t  src_val [NUM_SRCS];

  logic [NUM_REGS-1:0] gpr_in;
  logic [NUM_SRCS-1:0] out_sel;
  logic [NUM_OPS-1:0]  alu_op;

  assign gpr_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign out_sel = {Cout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                    R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign alu_op = {DIV, MUL, NOT, NEG, ROL, ROR, SHL, SHRA, SHR, OR, AND, SUB, ADD, IncPC};

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) src_val[i] = gpr[i];
    src_val[SRC_HI]     = hi_q;
    src_val[SRC_LO]     = lo_q;
    src_val[SRC_ZHIGH]  = z_q[2*DATA_W-1:DATA_W];
    src_val[SRC_ZLOW]   = z_q[DATA_W-1:0];
    src_val[SRC_PC]     = pc_q;
    src_val[SRC_MDR]    = mdr_q;
    src_val[SRC_INPORT] = '0;
    src_val[SRC_C]      = sext_c(ir_q[18:0]);
  end

  // Scan from the lowest-priority source upward so the lowest index wins
  always_comb begin
    bus = '0;
    for (int i = NUM_SRCS - 1; i >= 0; i--) begin
      if (out_sel[i]) bus = src_val[i];
    end
  end

  dp_alu u_alu (
    .a      (y_q),
    .b      (bus),
    .op     (alu_op),
    .result (alu_result)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!clear) begin
      // NOTE: the register file is flops, not RAM, so it is cleared element by element.
      for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (gpr_in[i]) gpr[i] <= bus;
      end
      if (HIin)  hi_q  <= bus;
      if (LOin)  lo_q  <= bus;
      if (PCin)  pc_q  <= bus;
      if (IRin)  ir_q  <= bus;
      if (MARin) mar_q <= bus;
      if (Yin)   y_q   <= bus;
      if (MDRin) mdr_q <= Read ? Mdatain : bus;
      if (Zin)   z_q   <= alu_result;
    end
  end

  assign R0  = gpr[0];
  assign R1  = gpr[1];
  assign R2  = gpr[2];
  assign R3  = gpr[3];
  assign R4  = gpr[4];
  assign R5  = gpr[5];
  assign R6  = gpr[6];
  assign R7  = gpr[7];
  assign R8  = gpr[8];
  assign R9  = gpr[9];
  assign R10 = gpr[10];
  assign R11 = gpr[11];
  assign R12 = gpr[12];
  assign R13 = gpr[13];
  assign R14 = gpr[14];
  assign R15 = gpr[15];

  assign HI               = hi_q;
  assign LO               = lo_q;
  assign PC_out           = pc_q;
  assign IR               = ir_q;
  assign MAR              = mar_q;
  assign Y                = y_q;
  assign Z                = z_q;
  assign BusMuxOut_signal = bus;

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: a stimulus process drives micro-steps and queues
// expected values from an arithmetic reference model; a monitor pops and compares.
module tb_data_path;

  // Destination (load) bit positions
  localparam int D_HI = 16, D_LO = 17, D_PC = 18, D_IR = 19, D_Y = 20, D_Z = 21, D_MAR = 22, D_MDR = 23;
  // Bus source bit positions
  localparam int S_HI = 16, S_LO = 17, S_ZH = 18, S_ZL = 19, S_PC = 20, S_MDR = 21, S_INP = 22, S_C = 23;
  // ALU op bit positions
  localparam int O_INC = 0, O_ADD = 1, O_SUB = 2, O_AND = 3, O_OR = 4, O_SHR = 5, O_SHRA = 6;
  localparam int O_SHL = 7, O_ROR = 8, O_ROL = 9, O_NEG = 10, O_NOT = 11, O_MUL = 12, O_DIV = 13;
  // Observed output ids
  localparam int K_HI = 16, K_LO = 17, K_PC = 18, K_IR = 19, K_MAR = 20, K_Y = 21, K_Z = 22, K_BUS = 23;

  typedef struct {
    int          due;
    int          sel;
    logic [63:0] exp;
    string       name;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear;
  logic [23:0] din, dout;
  logic [13:0] dop;
  logic        read;
  logic [31:0] mdatain;

  logic [15:0][31:0] r_q;
  logic [31:0] hi_q, lo_q, pc_q, ir_q, mar_q, y_q, bus_q;
  logic [63:0] z_q;

  // Reference model state
  logic [31:0] m_r [16];
  logic [31:0] m_hi, m_lo, m_pc, m_ir, m_mar, m_mdr, m_y;
  logic [63:0] m_z;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  data_path dut (
    .clock(clock), .clear(clear),
    .R0in(din[0]), .R1in(din[1]), .R2in(din[2]), .R3in(din[3]),
    .R4in(din[4]), .R5in(din[5]), .R6in(din[6]), .R7in(din[7]),
    .R8in(din[8]), .R9in(din[9]), .R10in(din[10]), .R11in(din[11]),
    .R12in(din[12]), .R13in(din[13]), .R14in(din[14]), .R15in(din[15]),
    .HIin(din[D_HI]), .LOin(din[D_LO]), .PCin(din[D_PC]), .IRin(din[D_IR]),
    .Yin(din[D_Y]), .Zin(din[D_Z]), .MARin(din[D_MAR]), .MDRin(din[D_MDR]),
    .R0out(dout[0]), .R1out(dout[1]), .R2out(dout[2]), .R3out(dout[3]),
    .R4out(dout[4]), .R5out(dout[5]), .R6out(dout[6]), .R7out(dout[7]),
    .R8out(dout[8]), .R9out(dout[9]), .R10out(dout[10]), .R11out(dout[11]),
    .R12out(dout[12]), .R13out(dout[13]), .R14out(dout[14]), .R15out(dout[15]),
    .HIout(dout[S_HI]), .LOout(dout[S_LO]), .Zhighout(dout[S_ZH]), .Zlowout(dout[S_ZL]),
    .PCout(dout[S_PC]), .MDRout(dout[S_MDR]), .InPortout(dout[S_INP]), .Cout(dout[S_C]),
    .IncPC(dop[O_INC]), .ADD(dop[O_ADD]), .SUB(dop[O_SUB]), .AND(dop[O_AND]),
    .OR(dop[O_OR]), .SHR(dop[O_SHR]), .SHRA(dop[O_SHRA]), .SHL(dop[O_SHL]),
    .ROR(dop[O_ROR]), .ROL(dop[O_ROL]), .NEG(dop[O_NEG]), .NOT(dop[O_NOT]),
    .MUL(dop[O_MUL]), .DIV(dop[O_DIV]),
    .Read(read), .Mdatain(mdatain),
    .R0(r_q[0]), .R1(r_q[1]), .R2(r_q[2]), .R3(r_q[3]),
    .R4(r_q[4]), .R5(r_q[5]), .R6(r_q[6]), .R7(r_q[7]),
    .R8(r_q[8]), .R9(r_q[9]), .R10(r_q[10]), .R11(r_q[11]),
    .R12(r_q[12]), .R13(r_q[13]), .R14(r_q[14]), .R15(r_q[15]),
    .HI(hi_q), .LO(lo_q), .PC_out(pc_q), .IR(ir_q), .MAR(mar_q), .Y(y_q),
    .Z(z_q), .BusMuxOut_signal(bus_q)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dut_val(input int sel);
    if (sel < 16) return {32'd0, r_q[sel]};
    case (sel)
      K_HI:    return {32'd0, hi_q};
      K_LO:    return {32'd0, lo_q};
      K_PC:    return {32'd0, pc_q};
      K_IR:    return {32'd0, ir_q};
      K_MAR:   return {32'd0, mar_q};
      K_Y:     return {32'd0, y_q};
      K_Z:     return z_q;
      default: return {32'd0, bus_q};
    endcase
  endfunction

  task automatic push(input int due, input int sel, input logic [63:0] v, input string name);
    exp_t e;
    e.due = due; e.sel = sel; e.exp = v; e.name = name;
    sb.push_back(e);
  endtask

  // Directed literal expectation for the state visible after the step just issued
  task automatic lit(input int sel, input logic [63:0] v, input string name);
    push(cyc + 1, sel, v, name);
  endtask

  function automatic logic [23:0] dbit(input int i);
    return 24'd1 << i;
  endfunction

  function automatic logic [13:0] obit(input int i);
    return 14'd1 << i;
  endfunction

  function automatic logic [31:0] model_bus(input logic [23:0] s);
    for (int i = 0; i < 24; i++) begin
      if (s[i]) begin
        if (i < 16) return m_r[i];
        case (i)
          S_HI:    return m_hi;
          S_LO:    return m_lo;
          S_ZH:    return m_z[63:32];
          S_ZL:    return m_z[31:0];
          S_PC:    return m_pc;
          S_MDR:   return m_mdr;
          S_INP:   return 32'd0;
          default: return 32'($signed(m_ir << 13) >>> 13);
        endcase
      end
    end
    return 32'd0;
  endfunction

  function automatic logic [63:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [13:0] op);
    int          sa;
    longint      la, lb;
    int unsigned sh;
    sa = a;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    sh = int'(b[4:0]);
    for (int k = 0; k < 14; k++) begin
      if (op[k]) begin
        case (k)
          O_INC:  return {32'd0, b + 32'd1};
          O_ADD:  return {32'd0, a + b};
          O_SUB:  return {32'd0, a - b};
          O_AND:  return {32'd0, a & b};
          O_OR:   return {32'd0, a | b};
          O_SHR:  return {32'd0, a >> sh};
          O_SHRA: return {32'd0, 32'(sa >>> sh)};
          O_SHL:  return {32'd0, a << sh};
          O_ROR:  return {32'd0, (a >> sh) | (a << (32 - sh))};
          O_ROL:  return {32'd0, (a << sh) | (a >> (32 - sh))};
          O_NEG:  return {32'd0, 32'd0 - a};
          O_NOT:  return {32'd0, ~a};
          O_MUL:  return 64'(la * lb);
          default: begin
            if (lb == 0) return 64'd0;
            return {32'(la % lb), 32'(la / lb)};
          end
        endcase
      end
    end
    return 64'd0;
  endfunction

  // One register-transfer cycle: drive, predict the bus now and the loads one edge later
  task automatic step(input logic [23:0] d, input logic [23:0] s, input logic [13:0] op,
                      input logic rd, input logic [31:0] md);
    logic [31:0] bv;
    logic [63:0] zv;
    @(posedge clock); #2;
    clear = 1'b1; din = d; dout = s; dop = op; read = rd; mdatain = md;
    bv = model_bus(s);
    zv = model_alu(m_y, bv, op);
    push(cyc, K_BUS, {32'd0, bv}, "bus");
    for (int i = 0; i < 16; i++) begin
      if (d[i]) begin
        m_r[i] = bv;
        push(cyc + 1, i, {32'd0, bv}, $sformatf("R%0d", i));
      end
    end
    if (d[D_HI])  begin m_hi  = bv; push(cyc + 1, K_HI,  {32'd0, bv}, "HI");  end
    if (d[D_LO])  begin m_lo  = bv; push(cyc + 1, K_LO,  {32'd0, bv}, "LO");  end
    if (d[D_PC])  begin m_pc  = bv; push(cyc + 1, K_PC,  {32'd0, bv}, "PC");  end
    if (d[D_IR])  begin m_ir  = bv; push(cyc + 1, K_IR,  {32'd0, bv}, "IR");  end
    if (d[D_MAR]) begin m_mar = bv; push(cyc + 1, K_MAR, {32'd0, bv}, "MAR"); end
    if (d[D_Y])   begin m_y   = bv; push(cyc + 1, K_Y,   {32'd0, bv}, "Y");   end
    if (d[D_Z])   begin m_z   = zv; push(cyc + 1, K_Z,   zv,          "Z");   end
    if (d[D_MDR]) m_mdr = rd ? md : bv;
  endtask

  task automatic reset_step(input logic [23:0] d);
    @(posedge clock); #2;
    clear = 1'b0; din = d; dout = '0; dop = '0; read = 1'b0; mdatain = '1;
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_hi = '0; m_lo = '0; m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0; m_y = '0; m_z = '0;
    for (int k = 0; k <= K_Z; k++) push(cyc + 1, k, 64'd0, $sformatf("reset_%0d", k));
  endtask

  task automatic load_mdr(input logic [31:0] v);
    step(dbit(D_MDR), '0, '0, 1'b1, v);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check(e.name, dut_val(e.sel), e.exp);
      end
    end
  end

  initial begin : stimulus
    logic [23:0] d, s;
    logic [13:0] op;
    logic [31:0] md;
    clear = 1'b0; din = '0; dout = '0; dop = '0; read = 1'b0; mdatain = '0;

    // Reset after arbitrary loads, with every load strobe high during clear
    reset_step('0);
    load_mdr(32'h1234_5678);
    step(dbit(3) | dbit(D_Y) | dbit(D_PC), dbit(S_MDR), '0, 1'b0, '0);
    step(dbit(D_Z), dbit(3), obit(O_ADD), 1'b0, '0);
    reset_step('1);

    // NEG
    load_mdr(32'h0000_000A);
    step(dbit(7), dbit(S_MDR), '0, 1'b0, '0);
    lit(7, 64'h0A, "neg_R7");
    step(dbit(D_Y), dbit(7), '0, 1'b0, '0);
    step(dbit(D_Z), '0, obit(O_NEG), 1'b0, '0);
    step(dbit(4), dbit(S_ZL), '0, 1'b0, '0);
    lit(4, 64'hFFFF_FFF6, "neg_R4");

    // Fetch from reset
    reset_step('0);
    step(dbit(D_MAR) | dbit(D_Z), dbit(S_PC), obit(O_INC), 1'b0, '0);
    lit(K_MAR, 64'd0, "fetch_MAR");
    lit(K_Z, 64'd1, "fetch_Z");
    step(dbit(D_PC) | dbit(D_MDR), dbit(S_ZL), '0, 1'b1, 32'h7270_0000);
    lit(K_PC, 64'd1, "fetch_PC");
    step(dbit(D_IR), dbit(S_MDR), '0, 1'b0, '0);
    lit(K_IR, 64'h7270_0000, "fetch_IR");

    // ADD / SUB
    load_mdr(32'h15); step(dbit(2), dbit(S_MDR), '0, 1'b0, '0);
    load_mdr(32'h07); step(dbit(3), dbit(S_MDR), '0, 1'b0, '0);
    step(dbit(D_Y), dbit(2), '0, 1'b0, '0);
    step(dbit(D_Z), dbit(3), obit(O_ADD), 1'b0, '0);
    lit(K_Z, 64'h1C, "add_Z");
    step(dbit(D_Z), dbit(3), obit(O_SUB), 1'b0, '0);
    lit(K_Z, 64'h0E, "sub_Z");

    // MUL / DIV
    load_mdr(32'hFFFF_FFFE); step(dbit(D_Y), dbit(S_MDR), '0, 1'b0, '0);
    load_mdr(32'd3);         step(dbit(5), dbit(S_MDR), '0, 1'b0, '0);
    step(dbit(D_Z), dbit(5), obit(O_MUL), 1'b0, '0);
    lit(K_Z, 64'hFFFF_FFFF_FFFF_FFFA, "mul_Z");
    step(dbit(D_HI), dbit(S_ZH), '0, 1'b0, '0);
    lit(K_HI, 64'hFFFF_FFFF, "mul_HI");
    step(dbit(D_LO), dbit(S_ZL), '0, 1'b0, '0);
    lit(K_LO, 64'hFFFF_FFFA, "mul_LO");
    load_mdr(32'd7);         step(dbit(D_Y), dbit(S_MDR), '0, 1'b0, '0);
    load_mdr(32'hFFFF_FFFE); step(dbit(6), dbit(S_MDR), '0, 1'b0, '0);
    step(dbit(D_Z), dbit(6), obit(O_DIV), 1'b0, '0);
    lit(K_Z, 64'h0000_0001_FFFF_FFFD, "div_Z");
    step(dbit(D_Z), '0, obit(O_DIV), 1'b0, '0);
    lit(K_Z, 64'd0, "div0_Z");

    // Shifts and rotates of 0x80000001 by 1
    load_mdr(32'h8000_0001); step(dbit(D_Y), dbit(S_MDR), '0, 1'b0, '0);
    load_mdr(32'd1);         step(dbit(8), dbit(S_MDR), '0, 1'b0, '0);
    step(dbit(D_Z), dbit(8), obit(O_SHR), 1'b0, '0);  lit(K_Z, 64'h4000_0000, "shr_Z");
    step(dbit(D_Z), dbit(8), obit(O_SHRA), 1'b0, '0); lit(K_Z, 64'hC000_0000, "shra_Z");
    step(dbit(D_Z), dbit(8), obit(O_SHL), 1'b0, '0);  lit(K_Z, 64'h0000_0002, "shl_Z");
    step(dbit(D_Z), dbit(8), obit(O_ROR), 1'b0, '0);  lit(K_Z, 64'hC000_0000, "ror_Z");
    step(dbit(D_Z), dbit(8), obit(O_ROL), 1'b0, '0);  lit(K_Z, 64'h0000_0003, "rol_Z");

    // Priorities, idle bus, self-transfer through Z
    step(dbit(9), dbit(3) | dbit(5) | dbit(S_HI), '0, 1'b0, '0);
    lit(9, 64'h07, "busprio_R9");
    step(dbit(D_Z), dbit(8), obit(O_SHR) | obit(O_SHL), 1'b0, '0);
    lit(K_Z, 64'h4000_0000, "aluprio_Z");
    step(dbit(10), '0, '0, 1'b0, '0);
    lit(10, 64'd0, "idle_R10");
    step(dbit(D_Z), dbit(S_ZL), obit(O_INC), 1'b0, '0);
    lit(K_Z, 64'h4000_0001, "zself_Z");
    load_mdr(32'h0004_0005); step(dbit(D_IR), dbit(S_MDR), '0, 1'b0, '0);
    step(dbit(11), dbit(S_C), '0, 1'b0, '0);
    lit(11, 64'hFFFC_0005, "cout_R11");

    // Randomized transfers against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99, 0) == 0) begin
        reset_step(24'($urandom()));
      end else begin
        s = ($urandom_range(7, 0) == 0) ? 24'd0 : dbit($urandom_range(23, 0));
        if ($urandom_range(4, 0) == 0) s = s | dbit($urandom_range(23, 0));
        d = dbit($urandom_range(23, 0));
        if ($urandom_range(2, 0) == 0) d = d | dbit($urandom_range(23, 0));
        if ($urandom_range(2, 0) == 0) d = d | dbit(D_Z);
        op = ($urandom_range(9, 0) == 0) ? 14'd0 : obit($urandom_range(13, 0));
        if ($urandom_range(5, 0) == 0) op = op | obit($urandom_range(13, 0));
        case ($urandom_range(7, 0))
          0:       md = 32'h8000_0000;
          1:       md = 32'hFFFF_FFFF;
          2:       md = 32'($urandom_range(40, 0));
          default: md = $urandom();
        endcase
        step(d, s, op, 1'($urandom_range(1, 0)), md);
      end
    end

    step('0, '0, '0, 1'b0, '0);
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
